// File: rtl/johnson_pkg.sv
// johnson_pkg: shared state type, widths and Johnson-code helpers.
package johnson_pkg;
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
    localparam int N_DEF = 4;
    localparam int IDX_W = $clog2(2 * N_DEF);
    function automatic logic jc_is_legal(input logic [31:0] jc, input int n);
        int t;
        t = 0;
        for (int i = 0; i < n - 1; i++) t += int'(jc[i] != jc[i + 1]);
        return t <= 1;
    endfunction
    // Phase 0 is the counter reset value (MSB set, rest clear).
    function automatic int jc_to_idx(input logic [31:0] jc, input int n);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) p += int'(jc[i]);
        return jc[n - 1] ? p - 1 : 2 * n - 1 - p;
    endfunction
endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check: combinational legality check and phase decode of a Johnson code.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              jc,
    output logic                      legal,
    output logic [$clog2(2*N)-1:0]    idx
);
    localparam int IW = $clog2(2 * N);
    always_comb begin
        legal = jc_is_legal(32'(jc), N);
        idx   = IW'(jc_to_idx(32'(jc), N));
    end
endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: samples a Johnson-coded bus, registers its phase index and
// tracks sequence lock with a saturating error count.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 3,
    parameter int ALLOW_HOLD = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jc_valid,
    input  logic [N-1:0]              jc,
    input  logic                      err_clr,
    output logic [$clog2(2*N)-1:0]    idx,
    output logic                      idx_valid,
    output logic                      illegal_code,
    output logic                      seq_err,
    output logic                      wrap,
    output logic                      locked,
    output logic [7:0]                err_cnt
);
    localparam int IW = $clog2(2 * N);
    localparam logic [IW-1:0] LAST = IW'(2 * N - 1);
    state_t state_q, state_d;
    logic [3:0] good_q, good_d, good_inc;
    logic [IW-1:0] prev_q, prev_d, idx_q, idx_d, dec, nxt;
    logic idx_valid_q, idx_valid_d, ill_q, ill_d, seq_q, seq_d, wrap_q, wrap_d;
    logic [7:0] err_q, err_d;
    logic legal, good_step, err_ev;
    johnson_code_check #(.N(N)) u_check (.jc(jc), .legal(legal), .idx(dec));
    // Explicit wrap keeps the mod-2N step correct when 2N is not a power of two.
    assign nxt       = (prev_q == LAST) ? '0 : prev_q + 1'b1;
    assign good_step = (dec == nxt) || (ALLOW_HOLD != 0 && dec == prev_q);
    assign good_inc  = (good_q == 4'hF) ? 4'hF : good_q + 4'd1;
    assign err_ev    = ill_d | seq_d;
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        prev_d      = prev_q;
        idx_d       = idx_q;
        idx_valid_d = 1'b0;
        ill_d       = 1'b0;
        seq_d       = 1'b0;
        wrap_d      = 1'b0;
        if (jc_valid && !legal) begin
            ill_d   = 1'b1;
            state_d = SEARCH;
        end else if (jc_valid) begin
            idx_valid_d = 1'b1;
            idx_d       = dec;
            prev_d      = dec;
            case (state_q)
                SEARCH: begin
                    good_d  = 4'd1;
                    state_d = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                end
                default: begin
                    if (good_step) begin
                        good_d  = good_inc;
                        wrap_d  = (state_q == LOCKED) && (prev_q == LAST) && (dec == '0);
                        state_d = (good_inc >= 4'(LOCK_CNT)) ? LOCKED : state_q;
                    end else begin
                        seq_d   = 1'b1;
                        good_d  = 4'd1;
                        state_d = ACQUIRE;
                    end
                end
            endcase
        end
        err_d = err_clr ? {7'd0, err_ev} : (err_ev && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            good_q      <= '0;
            prev_q      <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            ill_q       <= 1'b0;
            seq_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            prev_q      <= prev_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            ill_q       <= ill_d;
            seq_q       <= seq_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end
    assign idx          = idx_q;
    assign idx_valid    = idx_valid_q;
    assign illegal_code = ill_q;
    assign seq_err      = seq_q;
    assign wrap         = wrap_q;
    assign locked       = (state_q == LOCKED);
    assign err_cnt      = err_q;
endmodule
